grad_window_feeder: RTL and testbench

// - Producer side of the gradient datapath: turns a raster pixel stream into the
//   e1..e5 / mean_1 operand set consumed by the weighted-abs gradient stage.
// - Sliding 5-pixel horizontal window per line plus weighted local mean, registered,

---
 rtl/grad_window_feeder_pkg.sv | 18 +
 rtl/adder.sv | 12 +
 rtl/grad_mean5.sv | 41 ++++
 rtl/grad_window_feeder.sv | 139 +++++++++++++
 tb/tb_grad_window_feeder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/grad_window_feeder_pkg.sv
// Shared constants for the gradient window feeder: default widths, window shape
// and the weighted-mean scaling.
package grad_window_feeder_pkg;

   localparam int PIXEL_BW_DEFAULT = 12;
   localparam int MAX_LINE_DEFAULT = 4096;
   localparam int WINDOW_TAPS      = 5;
   localparam int HIST_DEPTH       = WINDOW_TAPS - 1;
   localparam int CENTRE_WEIGHT    = 4;
   localparam int CENTRE_SHIFT     = $clog2(CENTRE_WEIGHT);
   localparam int MEAN_SHIFT       = 3;

   // Weights sum to 8, so the raw sum needs MEAN_SHIFT extra bits to never wrap.
   function automatic int sum_width(input int pix_w);
      return pix_w + MEAN_SHIFT;
   endfunction

endpackage

// File: rtl/adder.sv
// Plain N-bit two-operand adder used as the building block of the mean chain.
module adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);

   assign y = a + b;

endmodule

// File: rtl/grad_mean5.sv
// Combinational weighted mean of a 5-tap window: (e1+e2+4*e3+e4+e5) >> 3.
module grad_mean5
   import grad_window_feeder_pkg::*;
#(
   parameter int pixelBitWidth = PIXEL_BW_DEFAULT
) (
   input  logic [pixelBitWidth-1:0] e1,
   input  logic [pixelBitWidth-1:0] e2,
   input  logic [pixelBitWidth-1:0] e3,
   input  logic [pixelBitWidth-1:0] e4,
   input  logic [pixelBitWidth-1:0] e5,
   output logic [pixelBitWidth-1:0] mean
);

   localparam int SW = sum_width(pixelBitWidth);

   logic [SW-1:0] operand [0:WINDOW_TAPS-1];
   logic [SW-1:0] partial [0:WINDOW_TAPS-1];

   assign operand[0] = SW'(e1);
   assign operand[1] = SW'(e2);
   assign operand[2] = SW'(e3) << CENTRE_SHIFT;
   assign operand[3] = SW'(e4);
   assign operand[4] = SW'(e5);

   assign partial[0] = operand[0];

   // Accumulate in operand order e1..e5 through a ripple of adders.
   generate
      for (genvar gi = 1; gi < WINDOW_TAPS; gi++) begin : g_chain
         adder #(.N(SW)) u_add (
            .a (partial[gi-1]),
            .b (operand[gi]),
            .y (partial[gi])
         );
      end
   endgenerate

   assign mean = pixelBitWidth'(partial[WINDOW_TAPS-1] >> MEAN_SHIFT);

endmodule

// File: rtl/grad_window_feeder.sv
// Raster-to-window feeder: keeps a 4-pixel line history, emits registered
// 5-pixel windows plus weighted mean with valid/ready on both sides.
module grad_window_feeder
   import grad_window_feeder_pkg::*;
#(
   parameter int pixelBitWidth = PIXEL_BW_DEFAULT,
   parameter int MAX_LINE      = MAX_LINE_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [pixelBitWidth-1:0] in_pixel,
   input  logic                     in_valid,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic [pixelBitWidth-1:0] e1,
   output logic [pixelBitWidth-1:0] e2,
   output logic [pixelBitWidth-1:0] e3,
   output logic [pixelBitWidth-1:0] e4,
   output logic [pixelBitWidth-1:0] e5,
   output logic [pixelBitWidth-1:0] mean_1,
   output logic                     out_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     err_overrun
);

   localparam int               COL_W    = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAX_LINE - 1);
   localparam logic [2:0]       CNT_FULL = 3'(HIST_DEPTH);

   logic [pixelBitWidth-1:0] w_q [1:HIST_DEPTH];
   logic [pixelBitWidth-1:0] w_d [1:HIST_DEPTH];
   logic [pixelBitWidth-1:0] e_q [1:WINDOW_TAPS];
   logic [pixelBitWidth-1:0] e_d [1:WINDOW_TAPS];
   logic [pixelBitWidth-1:0] mean_q, mean_d, mean_w;
   logic                     last_q, last_d;
   logic                     valid_q, valid_d;
   logic                     err_q, err_d;
   logic [2:0]               cnt_q, cnt_d;
   logic [COL_W-1:0]         col_q, col_d;
   logic                     accept;

   // Mean is computed on the window as it will be once in_pixel is appended.
   grad_mean5 #(.pixelBitWidth(pixelBitWidth)) u_mean (
      .e1   (w_q[1]),
      .e2   (w_q[2]),
      .e3   (w_q[3]),
      .e4   (w_q[4]),
      .e5   (in_pixel),
      .mean (mean_w)
   );

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      w_d     = w_q;
      e_d     = e_q;
      mean_d  = mean_q;
      last_d  = last_q;
      valid_d = valid_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      col_d   = col_q;

      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      if (accept) begin
         for (int i = 1; i < HIST_DEPTH; i++) begin
            w_d[i] = w_q[i+1];
         end
         w_d[HIST_DEPTH] = in_pixel;

         if (cnt_q == CNT_FULL) begin
            for (int i = 1; i <= HIST_DEPTH; i++) begin
               e_d[i] = w_q[i];
            end
            e_d[WINDOW_TAPS] = in_pixel;
            mean_d  = mean_w;
            last_d  = in_last;
            valid_d = 1'b1;
         end

         // A line end or an overrun both restart the window from column 0.
         if (in_last) begin
            cnt_d = '0;
            col_d = '0;
         end else if (col_q == COL_LAST) begin
            err_d = 1'b1;
            cnt_d = '0;
            col_d = '0;
         end else begin
            col_d = col_q + 1'b1;
            if (cnt_q != CNT_FULL) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i <= HIST_DEPTH; i++) begin
            w_q[i] <= '0;
         end
         for (int i = 1; i <= WINDOW_TAPS; i++) begin
            e_q[i] <= '0;
         end
         mean_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         col_q   <= '0;
      end else begin
         w_q     <= w_d;
         e_q     <= e_d;
         mean_q  <= mean_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
      end
   end

   assign e1          = e_q[1];
   assign e2          = e_q[2];
   assign e3          = e_q[3];
   assign e4          = e_q[4];
   assign e5          = e_q[5];
   assign mean_1      = mean_q;
   assign out_last    = last_q;
   assign out_valid   = valid_q;
   assign err_overrun = err_q;

endmodule

// File: tb/tb_grad_window_feeder.sv
// Bench for grad_window_feeder: cycle-level line/window model plus directed pins.
module tb_grad_window_feeder;

   localparam int P  = 12;
   localparam int ML = 8;

   logic         clk;
   logic         rst;
   logic [P-1:0] in_pixel;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [P-1:0] e1, e2, e3, e4, e5, mean_1;
   logic         out_last;
   logic         out_valid;
   logic         out_ready;
   logic         err_overrun;

   int checks = 0;
   int errors = 0;
   bit rand_mode = 0;

   // Behavioural model state: outputs as registered after the last edge.
   bit started = 0;
   bit m_valid, m_last, m_err;
   int m_e[5];
   int m_mean;
   int m_col;
   int hist[$];
   bit m_acc;
   int m_pix;

   grad_window_feeder #(.pixelBitWidth(P), .MAX_LINE(ML)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_pixel    (in_pixel),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .e1          (e1),
      .e2          (e2),
      .e3          (e3),
      .e4          (e4),
      .e5          (e5),
      .mean_1      (mean_1),
      .out_last    (out_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err_overrun (err_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare, then advance the model using the inputs the next edge will sample.
   always @(negedge clk) begin
      if (started) begin
         chk("out_valid", int'(out_valid), int'(m_valid));
         chk("in_ready", int'(in_ready), int'(!m_valid || out_ready));
         chk("err_overrun", int'(err_overrun), int'(m_err));
         chk("out_last", int'(out_last), int'(m_last));
         chk("e1", int'(e1), m_e[0]);
         chk("e2", int'(e2), m_e[1]);
         chk("e3", int'(e3), m_e[2]);
         chk("e4", int'(e4), m_e[3]);
         chk("e5", int'(e5), m_e[4]);
         chk("mean_1", int'(mean_1), m_mean);
      end
      if (rst) begin
         started = 1;
         m_valid = 0;
         m_last  = 0;
         m_err   = 0;
         m_e     = '{0, 0, 0, 0, 0};
         m_mean  = 0;
         m_col   = 0;
         hist.delete();
      end else if (started) begin
         m_acc = in_valid && (!m_valid || out_ready);
         if (m_valid && out_ready) m_valid = 0;
         if (m_acc) begin
            m_pix = int'(in_pixel);
            if (hist.size() == 4) begin
               m_e     = '{hist[0], hist[1], hist[2], hist[3], m_pix};
               m_mean  = (hist[0] + hist[1] + 4 * hist[2] + hist[3] + m_pix) / 8;
               m_last  = in_last;
               m_valid = 1;
            end
            if (in_last) begin
               hist.delete();
               m_col = 0;
            end else if (m_col == ML - 1) begin
               m_err = 1;
               hist.delete();
               m_col = 0;
            end else begin
               hist.push_back(m_pix);
               if (hist.size() > 4) void'(hist.pop_front());
               m_col++;
            end
         end
      end
   end

   always begin
      @(posedge clk);
      #2;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send_pixel(input int p, input bit last);
      int waitc;
      in_valid = 1'b1;
      in_pixel = P'(p);
      in_last  = last;
      waitc    = 0;
      @(negedge clk);
      while (!in_ready && waitc < 200) begin
         waitc++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_pixel  = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_err", int'(err_overrun), 0);
      chk("rst_e1", int'(e1), 0);
      chk("rst_mean", int'(mean_1), 0);

      // 10..50 window
      for (int k = 1; k <= 5; k++) send_pixel(10 * k, k == 5);
      chk("w10_valid", int'(out_valid), 1);
      chk("w10_e1", int'(e1), 10);
      chk("w10_e3", int'(e3), 30);
      chk("w10_e5", int'(e5), 50);
      chk("w10_mean", int'(mean_1), 30);
      chk("w10_model_mean", m_mean, 30);
      chk("w10_last", int'(out_last), 1);
      idle(2);

      send_pixel(0, 0); send_pixel(0, 0); send_pixel(1, 0); send_pixel(0, 0); send_pixel(7, 1);
      chk("floor_mean", int'(mean_1), 1);
      chk("floor_model_mean", m_mean, 1);
      idle(2);
      for (int k = 0; k < 5; k++) send_pixel(4095, k == 4);
      chk("max_mean", int'(mean_1), 4095);
      idle(2);

      // 7-pixel line then a fresh line
      for (int k = 1; k <= 7; k++) begin
         send_pixel(k, k == 7);
         chk("l7_valid", int'(out_valid), int'(k >= 5));
         if (k >= 5) begin
            chk("l7_e1", int'(e1), k - 4);
            chk("l7_last", int'(out_last), int'(k == 7));
         end
      end
      for (int k = 8; k <= 11; k++) begin
         send_pixel(k, 0);
         chk("fresh_no_emit", int'(out_valid), 0);
      end
      send_pixel(12, 1);
      chk("fresh_e1", int'(e1), 8);
      idle(2);

      // downstream stall
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) send_pixel(100 + k, k == 4);
      in_valid = 1'b1;
      in_pixel = 12'd200;
      in_last  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("hold_in_ready", int'(in_ready), 0);
         chk("hold_e5", int'(e5), 104);
         chk("hold_valid", int'(out_valid), 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) send_pixel(200 + k, k == 4);
      chk("resume_e1", int'(e1), 200);
      chk("resume_e5", int'(e5), 204);
      idle(2);

      // short line
      for (int k = 1; k <= 3; k++) begin
         send_pixel(k, k == 3);
         chk("short_no_emit", int'(out_valid), 0);
      end
      chk("short_err", int'(err_overrun), 0);
      idle(2);

      // overrun at MAX_LINE
      for (int k = 1; k <= 9; k++) begin
         send_pixel(300 + k, 0);
         if (k == 7) chk("ovr_err_before", int'(err_overrun), 0);
         if (k == 8) chk("ovr_err_set", int'(err_overrun), 1);
      end
      chk("ovr_no_emit", int'(out_valid), 0);
      for (int k = 10; k <= 13; k++) send_pixel(300 + k, k == 13);
      chk("ovr_new_e1", int'(e1), 309);
      chk("ovr_sticky", int'(err_overrun), 1);
      idle(2);

      // reset mid-line with a held window
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) send_pixel(400 + k, 0);
      in_valid = 1'b0;
      chk("pre_rst_valid", int'(out_valid), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_err", int'(err_overrun), 0);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) send_pixel(500 + k, k == 4);
      chk("post_rst_e1", int'(e1), 500);
      chk("post_rst_mean", int'(mean_1), 502);
      idle(2);

      // randomized lines with gaps and downstream backpressure
      rand_mode = 1;
      for (int ln = 0; ln < 60; ln++) begin
         int len;
         len = $urandom_range(1, 11);
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_pixel(int'($urandom_range(0, 4095)), j == len - 1);
         end
      end
      rand_mode = 0;
      @(posedge clk);
      #3;
      out_ready = 1'b1;
      idle(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
